cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
- FSM sequencing the data cache and block-wide data memory on a miss: optional dirty-line write-back, then block refill, then a one-cycle line fill into the cache.
- Sits in the memory stage beside the data cache; drives pipeline stall, data-memory request/write-enable/address, and the cache fill strobe.
- Keeps saturating miss/write-back statistics counters for performance checks.

Parameters:
- DATA_WIDTH, 32, address/word width.
- BLOCK_WIDTH, 128, cache line width in bits; the offset width is log2(BLOCK_WIDTH/8) = 4 at default.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  memory-stage access this cycle (MemRead | MemWrite).
- req_addr  input  DATA_WIDTH  byte address of access (ALUResult).
- hit  input  1  cache tag-compare hit for req_addr.
- victim_dirty  input  1  indexed line is valid and dirty.
- victim_addr  input  DATA_WIDTH  block-aligned address of indexed victim line.
- mem_ready  input  1  data memory completes the current request this cycle.
- stall  output  1  freeze PC and pipeline registers.
- mem_req  output  1  request to data memory.
- mem_we  output  1  request is a block write-back (1) or a block read (0).
- mem_addr  output  DATA_WIDTH  block-aligned memory address.
- fill_en  output  1  cache writes the fetched block, sets valid, clears dirty.
- busy  output  1  state != IDLE.
- miss_count  output  CNT_WIDTH  misses detected, saturating.
- wb_count  output  CNT_WIDTH  write-backs issued, saturating.

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- Reset forces state IDLE and clears the latched addresses and both counters. All outputs are 0 the cycle after reset. A reset mid-miss abandons the transaction with no fill_en.
- States:
  - IDLE:
    - If req_valid & ~hit, latch req_addr with the low offset bits zeroed into miss_addr, latch victim_addr into wb_addr, and increment miss_count.
    - Go to WRITEBACK if victim_dirty, otherwise go to REFILL.
    - If req_valid & hit, or if req_valid is 0, stay in IDLE.
  - WRITEBACK:
    - mem_req=1, mem_we=1, mem_addr=wb_addr. wb_count increments on entry.
    - On mem_ready, go to REFILL. Otherwise hold.
  - REFILL:
    - mem_req=1, mem_we=0, mem_addr=miss_addr.
    - On mem_ready, go to FILL. Otherwise hold.
  - FILL:
    - fill_en=1 for exactly one cycle, then go to IDLE.
    - The access replays in IDLE and must now hit.
- Outputs:
  - stall = (state==IDLE & req_valid & ~hit) | (state!=IDLE). It is combinational, so the miss cycle itself stalls.
  - In IDLE, mem_req, mem_we and fill_en are 0, and mem_addr = 0.
- mem_ready is sampled only in WRITEBACK and REFILL. A mem_ready in any other state is ignored.
- mem_ready high in the first cycle of a state is accepted, so the minimum penalty is:
  - clean miss: 3 stall cycles (IDLE-detect, REFILL, FILL);
  - dirty miss: 4 stall cycles.
- req_valid, hit and req_addr changes while busy are ignored; the pipeline holds them anyway.
- Back-to-back misses: a new miss is detected in the first IDLE cycle after FILL if the replayed or next access misses.
- Counters saturate at all-ones and do not wrap.
- mem_addr stays stable for the whole time mem_req is high.

Test Plan:
- Reset with req_valid=1, hit=0 held high -> all outputs 0 while rst=1; miss_count=0.
- Clean miss: req_addr=0x0000_1234, hit=0, victim_dirty=0, mem_ready=1 constant -> stall high 3 cycles; mem_req=1, mem_we=0, mem_addr=0x0000_1230 for 1 cycle; fill_en pulses once; miss_count=1, wb_count=0. Then hit=1 -> stall=0.
- Dirty miss, mem_ready delayed 2 cycles per request: req_addr=0x40, victim_addr=0x840 -> WRITEBACK with mem_we=1, mem_addr=0x840 for 3 cycles; then REFILL with mem_addr=0x40 for 3 cycles; then FILL; stall high 8 cycles; wb_count=1.
- Hit traffic: req_valid=1, hit=1 for 10 cycles -> stall=0, mem_req=0, counters unchanged.
- Reset asserted in REFILL -> next cycle IDLE, mem_req=0, fill_en never pulses, counters 0.
- Force miss_count to all-ones (CNT_WIDTH=2, 4 misses) -> miss_count stays 3.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the data cache: optional dirty write-back, block refill, one-cycle line fill.
// Also keeps saturating miss and write-back counters.
module cache_miss_ctrl #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WIDTH = 128,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic                  hit,
   input  logic                  victim_dirty,
   input  logic [DATA_WIDTH-1:0] victim_addr,
   input  logic                  mem_ready,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic                  fill_en,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  miss_count,
   output logic [CNT_WIDTH-1:0]  wb_count
);

   localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_WIDTH / 8);
   localparam logic [CNT_WIDTH-1:0] CntOne = 1;

   typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StFill} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] miss_addr_q, wb_addr_q;
   logic [CNT_WIDTH-1:0]  miss_count_q, wb_count_q;
   logic                  miss_det;

   assign miss_det = (state_q == StIdle) & req_valid & ~hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         miss_addr_q  <= '0;
         wb_addr_q    <= '0;
         miss_count_q <= '0;
         wb_count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (miss_det) begin
            miss_addr_q <= {req_addr[DATA_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            wb_addr_q   <= victim_addr;
            if (miss_count_q != '1) miss_count_q <= miss_count_q + CntOne;
            // Write-back is counted when it is entered, i.e. on a dirty miss.
            if (victim_dirty && (wb_count_q != '1)) wb_count_q <= wb_count_q + CntOne;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (miss_det) state_d = victim_dirty ? StWriteback : StRefill;
         end
         StWriteback: begin
            if (mem_ready) state_d = StRefill;
         end
         StRefill: begin
            if (mem_ready) state_d = StFill;
         end
         StFill: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      // The miss cycle itself stalls; masked during reset so outputs stay quiet.
      stall    = miss_det & ~rst;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      fill_en  = 1'b0;
      unique case (state_q)
         StIdle: ;
         StWriteback: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wb_addr_q;
         end
         StRefill: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = miss_addr_q;
         end
         StFill: begin
            stall   = 1'b1;
            fill_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign miss_count = miss_count_q;
   assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: each access is expanded into its expected per-cycle output
// sequence; counters are checked against saturating totals, including a 2-bit instance.
module tb_cache_miss_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        hit;
   logic        victim_dirty;
   logic [31:0] victim_addr;
   logic        mem_ready;
   logic        stall, mem_req, mem_we, fill_en, busy;
   logic [31:0] mem_addr;
   logic [15:0] miss_count, wb_count;
   logic        s_stall, s_mem_req, s_mem_we, s_fill_en, s_busy;
   logic [31:0] s_mem_addr;
   logic [1:0]  s_miss_count, s_wb_count;

   int checks = 0;
   int errors = 0;
   int misses = 0;
   int wbs    = 0;

   always #5 clk = ~clk;

   cache_miss_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .mem_ready(mem_ready),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .fill_en(fill_en), .busy(busy), .miss_count(miss_count), .wb_count(wb_count)
   );

   cache_miss_ctrl #(.CNT_WIDTH(2)) dut_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .mem_ready(mem_ready),
      .stall(s_stall), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
      .fill_en(s_fill_en), .busy(s_busy), .miss_count(s_miss_count), .wb_count(s_wb_count)
   );

   function automatic logic [31:0] sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; checks, then advances one cycle.
   task automatic tick(input logic e_stall, input logic e_req, input logic e_we,
                       input logic [31:0] e_addr, input logic e_fill, input logic e_busy,
                       input bit detect, input bit dirty);
      #1;
      chk("stall", stall, e_stall);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      if (e_req || !e_busy) chk("mem_addr", mem_addr, e_addr);
      chk("fill_en", fill_en, e_fill);
      chk("busy", busy, e_busy);
      chk("miss_count", miss_count, sat(misses, 65535));
      chk("wb_count", wb_count, sat(wbs, 65535));
      chk("miss_count_sat", s_miss_count, sat(misses, 3));
      chk("wb_count_sat", s_wb_count, sat(wbs, 3));
      @(posedge clk);
      if (detect) misses++;
      if (detect && dirty) wbs++;
      @(negedge clk);
   endtask

   task automatic scramble();
      req_valid    = 1'($urandom_range(0, 1));
      hit          = 1'($urandom_range(0, 1));
      req_addr     = $urandom;
      victim_dirty = 1'($urandom_range(0, 1));
      victim_addr  = $urandom;
   endtask

   task automatic do_miss(input logic [31:0] addr, input logic [31:0] victim, input bit dirty,
                          input int dw, input int dr);
      logic [31:0] blk;
      blk          = addr & 32'hFFFF_FFF0;
      req_valid    = 1'b1;
      hit          = 1'b0;
      req_addr     = addr;
      victim_dirty = dirty;
      victim_addr  = victim;
      mem_ready    = 1'($urandom_range(0, 1));
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, dirty);
      if (dirty) begin
         for (int k = 0; k <= dw; k++) begin
            scramble();
            mem_ready = (k == dw);
            tick(1'b1, 1'b1, 1'b1, victim, 1'b0, 1'b1, 1'b0, 1'b0);
         end
      end
      for (int k = 0; k <= dr; k++) begin
         scramble();
         mem_ready = (k == dr);
         tick(1'b1, 1'b1, 1'b0, blk, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      scramble();
      mem_ready = 1'($urandom_range(0, 1));
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      // Replay now hits.
      req_valid = 1'b1;
      hit       = 1'b1;
      req_addr  = addr;
      mem_ready = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b1;
      hit          = 1'b0;
      req_addr     = 32'h0000_1234;
      victim_dirty = 1'b1;
      victim_addr  = 32'h0;
      mem_ready    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Reset held with a pending miss: everything quiet.
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Clean miss, memory always ready.
      do_miss(32'h0000_1234, 32'h0000_5670, 1'b0, 0, 0);
      // Dirty miss, memory ready after 2 wait cycles per request.
      do_miss(32'h0000_0040, 32'h0000_0840, 1'b1, 2, 2);

      // Hit traffic.
      for (int i = 0; i < 10; i++) begin
         req_valid    = 1'b1;
         hit          = 1'b1;
         req_addr     = $urandom;
         victim_dirty = 1'($urandom_range(0, 1));
         mem_ready    = 1'($urandom_range(0, 1));
         tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Randomized mix of idle, hit and miss accesses.
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            scramble();
            req_valid = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         end else if (kind == 1) begin
            scramble();
            req_valid = 1'b1;
            hit       = 1'b1;
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         end else begin
            do_miss($urandom, $urandom & 32'hFFFF_FFF0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      // Reset while in refill abandons the miss.
      req_valid    = 1'b1;
      hit          = 1'b0;
      req_addr     = 32'h0000_2220;
      victim_dirty = 1'b0;
      mem_ready    = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 32'h0000_2220, 1'b0, 1'b1, 1'b0, 1'b0);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      misses = 0;
      wbs    = 0;
      @(negedge clk);
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst       = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
